// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage and its neighbours: control inputs from
// decode/execute, the program-load port, and the IF/ID register outputs.
//
// Handshake: there is no valid/ready pair here. valid_if qualifies IR_if and
// NPC_if on every cycle (0 = bubble), and stall is the only backpressure.
// While stall is high in RUN, IR_if/NPC_if/valid_if are held stable.
interface fetch_stage_if #(
  parameter int IMEM_DEPTH = 256
) ();
  localparam int AW = $clog2(IMEM_DEPTH);

  // Control from downstream stages
  logic          stall;
  logic          br_taken;
  logic [31:0]   br_target;
  logic          hlt;

  // Program-load port
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;

  // Fetch outputs (IF/ID register)
  logic [31:0]   pc;
  logic [31:0]   NPC_if;
  logic [31:0]   IR_if;
  logic          valid_if;
  logic          halted;

  // FSM state for observation (0 = RUN, 1 = HALTED)
  logic          state_dbg;

  // Driver of the controls and program loader
  modport master (
    output stall, br_taken, br_target, hlt,
    output im_we, im_addr, im_wdata,
    input  pc, NPC_if, IR_if, valid_if, halted, state_dbg
  );

  // The fetch stage itself
  modport slave (
    input  stall, br_taken, br_target, hlt,
    input  im_we, im_addr, im_wdata,
    output pc, NPC_if, IR_if, valid_if, halted, state_dbg
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of a 5-stage MIPS32 pipeline. Holds the PC and a
// local word-addressed instruction memory and fills the IF/ID register with
// one word per cycle. Handles decode stalls, taken-branch redirects (one
// bubble) and halting when an HLT reaches decode.
module fetch_stage #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  fetch_stage_if.slave bus
);

  localparam int AW = $clog2(IMEM_DEPTH);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  // Architectural state
  logic [31:0] pc_q,    pc_d;
  logic [31:0] npc_q,   npc_d;
  logic [31:0] ir_q,    ir_d;
  logic        valid_q, valid_d;
  logic [0:0]  state_q, state_d;

  // Instruction memory; not reset, contents undefined until loaded
  logic [31:0] imem [IMEM_DEPTH];

  // Fetch index: word address wraps modulo the memory depth
  logic [AW-1:0] fetch_idx;
  logic [31:0]   fetch_word;
  logic [31:0]   pc_plus4;

  // Target low bits are dropped: fetch is always word aligned
  logic [1:0]    unused_br_lsbs;
  assign unused_br_lsbs = bus.br_target[1:0];

  // Memory read is combinational off pc_q; because the write below is a
  // non-blocking update, a same-cycle write to this index yields old data.
  always_comb begin
    fetch_idx  = pc_q[AW+1:2];
    fetch_word = imem[fetch_idx];
    pc_plus4   = pc_q + 32'd4;
  end

  // Program-load port: writes in any state and never disturbs fetch
  always_ff @(posedge clk) begin
    if (bus.im_we) begin
      imem[bus.im_addr] <= bus.im_wdata;
    end
  end

  // Next-state logic, priority br_taken > halted/hlt > stall > fetch
  always_comb begin
    pc_d    = pc_q;
    npc_d   = npc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    state_d = state_q;

    if (bus.br_taken) begin
      // Redirect drops the wrong-path word; also the only exit from HALTED
      pc_d    = {bus.br_target[31:2], 2'b00};
      npc_d   = 32'h0000_0000;
      ir_d    = NOP_WORD;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (state_q == ST_HALTED) begin
      // Frozen: stall and hlt have no further effect
      pc_d    = pc_q;
    end else if (bus.hlt) begin
      // Stop fetching; pc and NPC stay where they are
      ir_d    = NOP_WORD;
      valid_d = 1'b0;
      state_d = ST_HALTED;
    end else if (bus.stall) begin
      // Hazard stall: everything holds
      pc_d    = pc_q;
    end else begin
      ir_d    = fetch_word;
      npc_d   = pc_plus4;
      pc_d    = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      npc_q   <= 32'h0000_0000;
      ir_q    <= NOP_WORD;
      valid_q <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  // Output mapping
  always_comb begin
    bus.pc        = pc_q;
    bus.NPC_if    = npc_q;
    bus.IR_if     = ir_q;
    bus.valid_if  = valid_q;
    bus.halted    = (state_q == ST_HALTED);
    bus.state_dbg = state_q[0];
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios from the pipeline behaviour,
// then randomized control traffic compared against a behavioural model.
module tb_fetch_stage;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic clk;
  logic rst;

  fetch_stage_if #(.IMEM_DEPTH(DEPTH)) bus ();

  fetch_stage #(
    .IMEM_DEPTH(DEPTH),
    .RESET_PC  (32'h0000_0000),
    .NOP_WORD  (NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / counters ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_npc, m_ir;
  logic        m_valid, m_halted;
  logic [31:0] m_mem [DEPTH];

  // Apply one clock edge worth of behaviour using the current inputs
  function automatic void model_step();
    int unsigned word_index;
    logic [31:0] word;
    word_index = (m_pc / 4) % DEPTH;
    word       = m_mem[word_index];
    if (rst) begin
      m_pc = 0; m_npc = 0; m_ir = NOP; m_valid = 0; m_halted = 0;
    end else if (bus.br_taken) begin
      m_pc = bus.br_target & 32'hFFFF_FFFC;
      m_npc = 0; m_ir = NOP; m_valid = 0; m_halted = 0;
    end else if (m_halted) begin
      // nothing moves
    end else if (bus.hlt) begin
      m_halted = 1; m_ir = NOP; m_valid = 0;
    end else if (!bus.stall) begin
      m_ir = word; m_npc = m_pc + 4; m_pc = m_pc + 4; m_valid = 1;
    end
    if (bus.im_we) m_mem[bus.im_addr] = bus.im_wdata;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_pc"},     bus.pc,                m_pc);
    check({tag, "_npc"},    bus.NPC_if,            m_npc);
    check({tag, "_ir"},     bus.IR_if,             m_ir);
    check({tag, "_valid"},  {31'd0, bus.valid_if}, {31'd0, m_valid});
    check({tag, "_halted"}, {31'd0, bus.halted},   {31'd0, m_halted});
  endtask

  // ---------------- driver ----------------
  task automatic set_ctl(input logic r, input logic s, input logic b,
                         input logic [31:0] t, input logic h);
    rst = r; bus.stall = s; bus.br_taken = b; bus.br_target = t; bus.hlt = h;
    bus.im_we = 1'b0; bus.im_addr = '0; bus.im_wdata = '0;
  endtask

  // One edge: DUT and model advance, then outputs are sampled 1 time unit later
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  logic [31:0] prog [4];
  logic [31:0] pc_hold;
  logic [31:0] w255;

  initial begin
    prog[0] = 32'h2010_0005; prog[1] = 32'h8C12_0004;
    prog[2] = 32'h0000_0000; prog[3] = 32'hFFFF_FFFF;
    w255    = 32'hA5A5_0FF0;
    set_ctl(1, 0, 0, 0, 0);

    // Program load under reset: every word defined
    for (int i = 0; i < DEPTH; i++) begin
      bus.im_we    = 1'b1;
      bus.im_addr  = i[7:0];
      bus.im_wdata = (i < 4) ? prog[i] : (i == 255) ? w255 : $urandom;
      cycle("load");
    end
    set_ctl(1, 0, 0, 0, 0);
    cycle("reset");
    check("rst_pc", bus.pc, 32'h0);
    check("rst_ir", bus.IR_if, NOP);
    check("rst_valid", {31'd0, bus.valid_if}, 32'd0);

    // 1: straight-line fetch
    exp_q.push_back(32'h2010_0005); exp_q.push_back(32'h8C12_0004); exp_q.push_back(32'h0000_0000);
    set_ctl(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle("t1");
      check("t1_ir_seq", bus.IR_if, exp_q.pop_front());
      check("t1_npc_seq", bus.NPC_if, 32'(4 * (i + 1)));
      check("t1_valid", {31'd0, bus.valid_if}, 32'd1);
    end

    // 2: stall holds after the first fetch
    set_ctl(1, 0, 0, 0, 0); cycle("t2_rst");
    set_ctl(0, 0, 0, 0, 0); cycle("t2_f0");
    set_ctl(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle("t2_stall");
      check("t2_ir_hold", bus.IR_if, 32'h2010_0005);
      check("t2_npc_hold", bus.NPC_if, 32'h4);
      check("t2_pc_hold", bus.pc, 32'h4);
    end
    set_ctl(0, 0, 0, 0, 0); cycle("t2_rel");
    check("t2_next", bus.IR_if, 32'h8C12_0004);

    // 3: branch beats stall, misaligned target is word-aligned
    set_ctl(0, 1, 1, 32'h0000_000E, 0); cycle("t3_br");
    check("t3_pc", bus.pc, 32'h0000_000C);
    check("t3_bubble", bus.IR_if, NOP);
    check("t3_valid", {31'd0, bus.valid_if}, 32'd0);
    set_ctl(0, 0, 0, 0, 0); cycle("t3_f");
    check("t3_ir", bus.IR_if, 32'hFFFF_FFFF);
    check("t3_npc", bus.NPC_if, 32'h10);

    // 4: halt, frozen despite stall, branch out; hlt+br together
    pc_hold = bus.pc;
    set_ctl(0, 0, 0, 0, 1); cycle("t4_hlt");
    check("t4_halted", {31'd0, bus.halted}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      set_ctl(0, i[0], 0, 0, i[1]); cycle("t4_frozen");
      check("t4_pc_frozen", bus.pc, pc_hold);
    end
    set_ctl(0, 0, 1, 32'h0, 0); cycle("t4_br");
    check("t4_unhalt", {31'd0, bus.halted}, 32'd0);
    set_ctl(0, 0, 0, 0, 0); cycle("t4_resume");
    check("t4_resume_ir", bus.IR_if, 32'h2010_0005);
    set_ctl(0, 0, 1, 32'h4, 1); cycle("t4_hlt_br");
    check("t4_hlt_br_halted", {31'd0, bus.halted}, 32'd0);
    check("t4_hlt_br_pc", bus.pc, 32'h4);

    // 5: index wrap and 32-bit pc wrap
    set_ctl(0, 0, 1, 32'h0000_03FC, 0); cycle("t5_br");
    set_ctl(0, 0, 0, 0, 0); cycle("t5_f255");
    check("t5_ir255", bus.IR_if, w255);
    cycle("t5_f0");
    check("t5_ir0", bus.IR_if, 32'h2010_0005);
    set_ctl(0, 0, 1, 32'hFFFF_FFFC, 0); cycle("t5_brtop");
    set_ctl(0, 0, 0, 0, 0); cycle("t5_wrap");
    check("t5_pc_wrap", bus.pc, 32'h0);
    check("t5_npc_wrap", bus.NPC_if, 32'h0);

    // Read-before-write on the index being fetched
    set_ctl(0, 0, 1, 32'h8, 0); cycle("rbw_br");
    set_ctl(0, 0, 0, 0, 0);
    bus.im_we = 1'b1; bus.im_addr = 8'd2; bus.im_wdata = 32'h1234_5678;
    cycle("rbw_f");
    check("rbw_old", bus.IR_if, 32'h0000_0000);

    // 6: reset mid-run with stall pending, memory survives
    set_ctl(1, 1, 0, 0, 0); cycle("t6_rst");
    check("t6_pc", bus.pc, 32'h0);
    check("t6_npc", bus.NPC_if, 32'h0);
    set_ctl(0, 0, 0, 0, 0); cycle("t6_f0");
    check("t6_ir", bus.IR_if, 32'h2010_0005);
    cycle("t6_f1");
    cycle("t6_f2");
    check("t6_new_word", bus.IR_if, 32'h1234_5678);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      set_ctl($urandom_range(0, 99) < 1,
              $urandom_range(0, 99) < 30,
              $urandom_range(0, 99) < 8,
              ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023)),
              $urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 20) begin
        bus.im_we    = 1'b1;
        bus.im_addr  = 8'($urandom_range(0, DEPTH - 1));
        bus.im_wdata = $urandom;
      end
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
